// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Sequences one 2-bit ripple-carry slice (two chained full adders)
//            across WIDTH-bit operands, two bits per clock, LSB pair first,
//            with a registered carry between slices. Start/done handshake.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous active-high reset
//            start      - request, sampled while in IDLE or DONE
//            a, b       - operands, captured on the accepting edge
//            carry_in   - carry into bit 0, captured on the accepting edge
//            busy       - high while the slice is being sequenced
//            done       - one-cycle pulse, result valid
//            sum        - registered result, held until the next completion
//            carry_out  - registered carry out of bit WIDTH-1
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int HALF  = WIDTH / 2;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(HALF - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;

    logic             w_accept;
    logic             w_busy;
    logic             w_done;
    logic [1:0]       w_op_a;
    logic [1:0]       w_op_b;
    logic [1:0]       w_slice_sum;
    logic [2:0]       w_c;
    logic [WIDTH-1:0] w_acc_next;

    // New operands are taken whenever the controller is not mid-operation.
    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_RUN;
            c_RUN:   if (r_idx == c_LAST_IDX) w_state_next = c_DONE;
            c_DONE:  w_state_next = start ? c_RUN : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (decoded from the state register only)
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_RUN:   w_busy = 1'b1;
            c_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign sum       = r_sum;
    assign carry_out = r_carry_out;

    // ------------------------------------------------------------------
    // 2-bit ripple slice: current operand pair plus registered carry
    // ------------------------------------------------------------------
    assign w_op_a = r_a[{r_idx, 1'b0} +: 2];
    assign w_op_b = r_b[{r_idx, 1'b0} +: 2];
    assign w_c[0] = r_carry;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fa
        assign w_slice_sum[gi] = w_op_a[gi] ^ w_op_b[gi] ^ w_c[gi];
        assign w_c[gi+1]       = (w_op_a[gi] & w_op_b[gi])
                               | (w_c[gi] & (w_op_a[gi] ^ w_op_b[gi]));
    end

    // Accumulator with the current slice merged in; on the last slice this
    // is the complete result, so it can be published in the same edge.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[{r_idx, 1'b0} +: 2] = w_slice_sum;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= carry_in;
            r_idx   <= '0;
        end else if (r_state == c_RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= w_c[2];
            r_idx   <= r_idx + 1'b1;
            if (r_idx == c_LAST_IDX) begin
                r_sum       <= w_acc_next;
                r_carry_out <= w_c[2];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Purpose  : Self-checking bench for serial_adder_ctrl (WIDTH=16 and WIDTH=2)
//            with an in-bench behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int W   = 16;
    localparam int LAT = W / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          co;

    logic          start2;
    logic [1:0]    a2;
    logic [1:0]    b2;
    logic          cin2;
    logic          busy2;
    logic          done2;
    logic [1:0]    sum2;
    logic          co2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(cin),
        .busy(busy), .done(done), .sum(sum), .carry_out(co)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .carry_in(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .carry_out(co2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a request taken while idle produces a+b+cin after
    // exactly LAT edges; requests arriving while a result is pending are
    // dropped.
    // ------------------------------------------------------------------
    int          m_rem  = 0;
    logic [W:0]  m_res  = '0;
    logic [W-1:0] m_sum = '0;
    logic        m_co   = 1'b0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_res  <= '0;
            m_sum  <= '0;
            m_co   <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    {m_co, m_sum} <= m_res;
                    m_done        <= 1'b1;
                end
            end else if (start) begin
                m_res <= (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
                m_rem <= LAT;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_rem != 0));
            check("done", 32'(done), 32'(m_done));
            check("sum", 32'(sum), 32'(m_sum));
            check("carry_out", 32'(co), 32'(m_co));
            check("busy_done_excl", 32'(busy & done), 32'd0);
        end
    end

    // Waits (bounded) for done, counting negedges on which busy was seen.
    task automatic wait_done(output int busy_cnt);
        int k;
        k = 0;
        busy_cnt = 0;
        while (!done && k < 24) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done expected done within 24 cycles");
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic [W-1:0] exp_sum, input logic exp_co,
                          input logic [W-1:0] prev_sum);
        int acc;
        int bc;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; cin = tc;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        check("hold_prev_sum", 32'(sum), 32'(prev_sum));
        wait_done(bc);
        check("latency", 32'(cyc - acc), 32'(LAT));
        check("busy_cycles", 32'(bc), 32'(LAT));
        check("lit_sum", 32'(sum), 32'(exp_sum));
        check("lit_co", 32'(co), 32'(exp_co));
    endtask

    initial begin
        int acc;
        int bc;
        int t1;
        int seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        chk_en = 1'b1;

        // Directed cases
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 16'h0000);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'h5555);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 16'h0000);

        // Second request during RUN must be ignored
        @(negedge clk);
        start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0; acc = cyc;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 16'h7777;
        @(negedge clk);
        start = 1'b0; a = 16'h0001;
        wait_done(bc);
        check("ignore_latency", 32'(cyc - acc), 32'(LAT));
        check("ignore_sum", 32'(sum), 32'h0002);
        @(negedge clk);
        check("ignore_no_rerun", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_co", 32'(co), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("arst_no_done", 32'(seen), 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 16'h0000);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; a = 16'h0F0F; b = 16'h00F1; cin = 1'b0;
        @(negedge clk);
        wait_done(bc);
        t1 = cyc;
        check("b2b_sum1", 32'(sum), 32'h1000);
        check("b2b_co1", 32'(co), 32'd0);
        a = 16'h8000; b = 16'h8000;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        check("b2b_gap", 32'(cyc - t1), 32'(LAT + 1));
        check("b2b_sum2", 32'(sum), 32'h0000);
        check("b2b_co2", 32'(co), 32'd1);

        // WIDTH=2 instance
        check("w2_rst_sum", 32'(sum2), 32'd0);
        @(negedge clk);
        start2 = 1'b1; a2 = 2'b11; b2 = 2'b01; cin2 = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
        check("w2_busy", 32'(busy2), 32'd1);
        check("w2_done_early", 32'(done2), 32'd0);
        @(negedge clk);
        check("w2_done", 32'(done2), 32'd1);
        check("w2_busy_off", 32'(busy2), 32'd0);
        check("w2_sum", 32'(sum2), 32'd0);
        check("w2_co", 32'(co2), 32'd1);

        // Randomized traffic, checked against the model every cycle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            b   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            cin = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + 3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Multi-cycle controller that sequences a single 2-bit ripple-carry adder slice (two chained 1-bit full adders) across WIDTH-bit operands, two bits per clock, LSB pair first, with a registered inter-slice carry. It gives the datapath a start/done handshake so wide additions reuse one small structural adder instead of a full-width ripple chain. It sits between an operand-producing master and any consumer of the registered sum/carry result.

## Interface
- WIDTH, 16, operand/result width in bits; must be even and ≥ 2
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  reset, asynchronous, active-high; forces IDLE and clears all registers
- start  input  1  request; sampled on rising clk while accepting (IDLE or DONE)
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- carry_in  input  1  carry into bit 0; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; holds until the next completion
- carry_out  output  1  registered carry out of bit WIDTH-1; holds with sum

## Operation
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry_out=0, slice index=0, carry register=0, operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b, carry_in into operand and carry registers, index=0, go to RUN. start=0 → stay.
- RUN: each cycle the slice takes operand bits [2i+1:2i] plus the carry register. Its two sum bits are written into the internal accumulator at [2i+1:2i], and its carry out is written back into the carry register. index increments.
  - On the cycle with index = WIDTH/2-1, the full accumulator and the final carry are copied into sum/carry_out, and the state goes to DONE.
  - start is ignored in RUN; operands do not change mid-operation.
- DONE: done=1 for exactly one cycle. start=1 → accept new operands as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- Arithmetic: {carry_out, sum} = a + b + carry_in, computed modulo 2^(WIDTH+1). There is no overflow flag.
- sum and carry_out change only on the edge entering DONE. Intermediate slice results are never visible on the outputs.
- Reset asserted mid-RUN: the operation is discarded, all outputs return to reset values immediately (asynchronous), and no done pulse is produced.

## Timing
- Accepting edge E0 (start=1 sampled) → busy=1 from E0 until E(WIDTH/2). done=1 and the new sum are visible after E(WIDTH/2), for one cycle.
- Latency from the accepting edge to done: WIDTH/2 cycles (16 → 8; 2 → 1).
- Back-to-back throughput: one result per WIDTH/2+1 cycles when start is held high.
- busy and done are never high together.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, carry_in=0, start 1 cycle → done exactly 8 cycles after the accepting edge, sum=0x5555, carry_out=0, busy high for 8 cycles.
- a=0xFFFF, b=0x0001, carry_in=0 → sum=0x0000, carry_out=1. The carry must propagate across all 8 slices.
- a=0xFFFF, b=0xFFFF, carry_in=1 → sum=0xFFFF, carry_out=1. Prior result stays on the outputs until done.
- Start a=0x0001, b=0x0001; pulse start with a=0x7777 at cycle 3 of RUN → result 0x0002, single done pulse, second request ignored.
- Assert rst at cycle 4 of RUN → busy, done, sum and carry_out go to 0 before the next edge, no done pulse follows, and a fresh start after release completes normally.
- Hold start=1 with alternating operands (0x0F0F+0x00F1, then 0x8000+0x8000) → results 0x1000/co=0 then 0x0000/co=1, with done pulses 9 cycles apart. Repeat with WIDTH=2: 2'b11+2'b01 → sum=2'b00, co=1, latency 1.
